pipe_hazard_ctrl: RTL and testbench

Registered, parametrised pipeline control and hazard unit for the 16-bit five-stage CPU.
- Decodes the fetch-buffer instruction into ID/EX control.
- Tracks destinations through EX/MEM and MEM/WB.
- Generates forwarding selects, load-use stalls, branch flushes, multi-cycle MUL/DIV stalls and halt drain.
- Sits between the fetch buffer / PC mux and the datapath muxes, replacing the purely combinational control.

---
 rtl/pipe_ctrl_pkg.sv | 81 ++++++++
 rtl/ctrl_decoder.sv | 88 ++++++++
 rtl/pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and stage record for the five-stage pipeline control unit.
package pipe_ctrl_pkg;

  localparam int REG_AW = 4;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1011;
  localparam logic [3:0] OP_BLT   = 4'b0100;
  localparam logic [3:0] OP_BGT   = 4'b0101;
  localparam logic [3:0] OP_BE    = 4'b0110;
  localparam logic [3:0] OP_JUMP  = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] FN_ADD = 4'b1111;
  localparam logic [3:0] FN_SUB = 4'b1110;
  localparam logic [3:0] FN_AND = 4'b1101;
  localparam logic [3:0] FN_OR  = 4'b1100;
  localparam logic [3:0] FN_MUL = 4'b0001;
  localparam logic [3:0] FN_DIV = 4'b0010;
  localparam logic [3:0] FN_LSL = 4'b1010;
  localparam logic [3:0] FN_LSR = 4'b1011;
  localparam logic [3:0] FN_RL  = 4'b1000;
  localparam logic [3:0] FN_RR  = 4'b1001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_DIV = 4'b0101;
  localparam logic [3:0] ALU_LSL = 4'b0110;
  localparam logic [3:0] ALU_LSR = 4'b0111;
  localparam logic [3:0] ALU_RL  = 4'b1000;
  localparam logic [3:0] ALU_RR  = 4'b1001;

  localparam logic [1:0] RW_NONE   = 2'b00;
  localparam logic [1:0] RW_OP1    = 2'b01;
  localparam logic [1:0] RW_OP1_R0 = 2'b11;

  localparam logic [1:0] CMP_BLT  = 2'b00;
  localparam logic [1:0] CMP_BGT  = 2'b01;
  localparam logic [1:0] CMP_BE   = 2'b10;
  localparam logic [1:0] CMP_NONE = 2'b11;

  localparam logic [1:0] PC_HOLD   = 2'b00;
  localparam logic [1:0] PC_INC    = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic [1:0]        reg_write;
    logic              is_load;
  } stage_t;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  // MUL/DIV also write R0, so a double-write stage matches source R0 too.
  function automatic logic stage_hits(input stage_t st, input logic [REG_AW-1:0] src);
    return st.valid && (st.reg_write != RW_NONE) &&
           ((st.dest == src) || ((st.reg_write == RW_OP1_R0) && (src == '0)));
  endfunction

  function automatic logic [1:0] fwd_select(input logic used, input logic [REG_AW-1:0] src,
                                            input stage_t younger, input stage_t older);
    if (!used)                    return FWD_RF;
    if (stage_hits(younger, src)) return FWD_EXMEM;
    if (stage_hits(older, src))   return FWD_MEMWB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational decode of one instruction into EX control fields, source usage and illegal.
module ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int RADDR_W = 4
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [RADDR_W-1:0] op1,
  output logic [RADDR_W-1:0] op2,
  output logic [3:0]         alu_op,
  output logic [1:0]         reg_write,
  output logic [1:0]         compare,
  output logic [1:0]         src_b,
  output logic               mem_to_reg,
  output logic               mem_wen,
  output logic               is_branch,
  output logic               is_jump,
  output logic               is_halt,
  output logic               is_muldiv,
  output logic               use_a,
  output logic               use_b,
  output logic               illegal
);

  logic [3:0] opcode;
  logic [3:0] funct;

  assign opcode = instr[15:12];
  assign op1    = instr[11:8];
  assign op2    = instr[7:4];
  assign funct  = instr[3:0];

  always_comb begin
    alu_op     = ALU_ADD;
    reg_write  = RW_NONE;
    compare    = CMP_NONE;
    src_b      = SRCB_REG;
    mem_to_reg = 1'b0;
    mem_wen    = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_halt    = 1'b0;
    is_muldiv  = 1'b0;
    use_a      = 1'b0;
    use_b      = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        use_a     = 1'b1;
        use_b     = 1'b1;
        reg_write = RW_OP1;
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_MUL: begin alu_op = ALU_MUL; is_muldiv = 1'b1; reg_write = RW_OP1_R0; end
          FN_DIV: begin alu_op = ALU_DIV; is_muldiv = 1'b1; reg_write = RW_OP1_R0; end
          FN_LSL: begin alu_op = ALU_LSL; src_b = SRCB_IMM; end
          FN_LSR: begin alu_op = ALU_LSR; src_b = SRCB_IMM; end
          FN_RL:  begin alu_op = ALU_RL;  src_b = SRCB_IMM; end
          FN_RR:  begin alu_op = ALU_RR;  src_b = SRCB_IMM; end
          default: illegal = 1'b1;
        endcase
        // Destination R0 would collide with the high/remainder write.
        if (is_muldiv && (op1 == '0)) illegal = 1'b1;
      end
      OP_LOAD:  begin reg_write = RW_OP1; mem_to_reg = 1'b1; src_b = SRCB_IMM; use_b = 1'b1; end
      OP_STORE: begin mem_wen = 1'b1; src_b = SRCB_IMM; use_a = 1'b1; use_b = 1'b1; end
      OP_BLT:   begin compare = CMP_BLT; is_branch = 1'b1; use_a = 1'b1; use_b = 1'b1; end
      OP_BGT:   begin compare = CMP_BGT; is_branch = 1'b1; use_a = 1'b1; use_b = 1'b1; end
      OP_BE:    begin compare = CMP_BE;  is_branch = 1'b1; use_a = 1'b1; use_b = 1'b1; end
      OP_JUMP:  is_jump = 1'b1;
      OP_HALT:  is_halt = 1'b1;
      default:  illegal = 1'b1;
    endcase
    if (illegal) begin
      alu_op    = ALU_ADD;
      reg_write = RW_NONE;
      src_b     = SRCB_REG;
      is_muldiv = 1'b0;
      use_a     = 1'b0;
      use_b     = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Registered pipeline control: decode into ID/EX, destination tracking, forwarding,
// load-use / MUL-DIV stalls, branch flush and the halt drain FSM.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INSTR_W       = 16,
  parameter int RADDR_W       = 4,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               if_valid,
  input  logic               branch_taken,
  output logic [1:0]         pc_sel,
  output logic               if_stall,
  output logic               flush,
  output logic [3:0]         ex_alu_op,
  output logic [1:0]         ex_reg_write,
  output logic [1:0]         ex_compare,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_wen,
  output logic [1:0]         ex_src_b,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               illegal,
  output logic               halted
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  state_t            state, state_nxt;
  stage_t            idex, exmem, memwb, entry;
  logic [CNT_W-1:0]  md_cnt;
  logic              accept, hold;
  logic              branch_flush, md_stall, load_use;
  logic [1:0]        fwd_a_nxt, fwd_b_nxt;

  logic [RADDR_W-1:0] d_op1, d_op2;
  logic [3:0]         d_alu_op;
  logic [1:0]         d_reg_write, d_compare, d_src_b;
  logic               d_mem_to_reg, d_mem_wen, d_is_branch, d_is_jump, d_is_halt;
  logic               d_is_muldiv, d_use_a, d_use_b, d_illegal;

  ctrl_decoder #(.INSTR_W(INSTR_W), .RADDR_W(RADDR_W)) u_dec (
    .instr(if_instr), .op1(d_op1), .op2(d_op2), .alu_op(d_alu_op),
    .reg_write(d_reg_write), .compare(d_compare), .src_b(d_src_b),
    .mem_to_reg(d_mem_to_reg), .mem_wen(d_mem_wen), .is_branch(d_is_branch),
    .is_jump(d_is_jump), .is_halt(d_is_halt), .is_muldiv(d_is_muldiv),
    .use_a(d_use_a), .use_b(d_use_b), .illegal(d_illegal)
  );

  // The branch in EX is recognised by its registered compare field.
  assign branch_flush = idex.valid && (ex_compare != CMP_NONE) && branch_taken;
  assign md_stall     = (md_cnt != '0);
  assign load_use     = if_valid && idex.valid && idex.is_load &&
                        ((d_use_a && (idex.dest == d_op1)) || (d_use_b && (idex.dest == d_op2)));

  assign fwd_a_nxt = fwd_select(d_use_a, d_op1, idex, exmem);
  assign fwd_b_nxt = fwd_select(d_use_b, d_op2, idex, exmem);

  always_comb begin
    entry = '0;
    if (accept && !d_illegal) begin
      entry.valid     = 1'b1;
      entry.dest      = d_op1;
      entry.reg_write = d_reg_write;
      entry.is_load   = d_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pc_sel    = PC_INC;
    if_stall  = 1'b0;
    flush     = 1'b0;
    accept    = 1'b0;
    hold      = 1'b0;
    case (state)
      ST_RUN: begin
        if (branch_flush) begin
          pc_sel = PC_BRANCH;
          flush  = 1'b1;
        end else if (md_stall) begin
          pc_sel   = PC_HOLD;
          if_stall = 1'b1;
          hold     = 1'b1;
        end else if (load_use) begin
          pc_sel   = PC_HOLD;
          if_stall = 1'b1;
        end else if (if_valid && d_is_halt) begin
          pc_sel    = PC_HOLD;
          if_stall  = 1'b1;
          state_nxt = ST_DRAIN;
        end else begin
          accept = if_valid;
          if (if_valid && d_is_jump) pc_sel = PC_JUMP;
        end
      end
      ST_DRAIN: begin
        pc_sel   = PC_HOLD;
        if_stall = 1'b1;
        hold     = md_stall;
        if (!idex.valid && !exmem.valid && !memwb.valid) state_nxt = ST_HALTED;
      end
      ST_HALTED: begin
        pc_sel   = PC_HOLD;
        if_stall = 1'b1;
      end
      default: state_nxt = ST_RUN;
    endcase
    if (rst) begin
      pc_sel   = PC_INC;
      if_stall = 1'b0;
      flush    = 1'b0;
    end
  end

  // A held MUL/DIV keeps its EX controls while bubbles trickle into EX/MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex          <= '0;
      exmem         <= '0;
      memwb         <= '0;
      md_cnt        <= '0;
      ex_alu_op     <= ALU_ADD;
      ex_reg_write  <= RW_NONE;
      ex_compare    <= CMP_NONE;
      ex_mem_to_reg <= 1'b0;
      ex_mem_wen    <= 1'b0;
      ex_src_b      <= SRCB_REG;
      fwd_a         <= FWD_RF;
      fwd_b         <= FWD_RF;
      illegal       <= 1'b0;
      halted        <= 1'b0;
    end else begin
      halted <= (state == ST_HALTED);
      memwb  <= exmem;
      if (hold) begin
        exmem   <= '0;
        md_cnt  <= md_cnt - 1'b1;
        illegal <= 1'b0;
      end else begin
        exmem   <= idex;
        idex    <= entry;
        md_cnt  <= (accept && d_is_muldiv) ? CNT_W'(MULDIV_CYCLES - 1) : '0;
        illegal <= accept && d_illegal;
        if (accept) begin
          ex_alu_op     <= d_alu_op;
          ex_reg_write  <= d_reg_write;
          ex_compare    <= d_compare;
          ex_mem_to_reg <= d_mem_to_reg;
          ex_mem_wen    <= d_mem_wen;
          ex_src_b      <= d_src_b;
          fwd_a         <= fwd_a_nxt;
          fwd_b         <= fwd_b_nxt;
        end else begin
          ex_alu_op     <= ALU_ADD;
          ex_reg_write  <= RW_NONE;
          ex_compare    <= CMP_NONE;
          ex_mem_to_reg <= 1'b0;
          ex_mem_wen    <= 1'b0;
          ex_src_b      <= SRCB_REG;
          fwd_a         <= FWD_RF;
          fwd_b         <= FWD_RF;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed hazard sequence then random traffic, compared each
// cycle against an instruction-level model of the pipeline.
module tb_pipe_hazard_ctrl;

  localparam int MDC  = 4;
  localparam int NDIR = 11;

  logic        clk = 1'b0;
  logic        rst, if_valid, branch_taken;
  logic [15:0] if_instr;
  logic [1:0]  pc_sel, ex_reg_write, ex_compare, ex_src_b, fwd_a, fwd_b;
  logic [3:0]  ex_alu_op;
  logic        if_stall, flush, ex_mem_to_reg, ex_mem_wen, illegal, halted;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.INSTR_W(16), .RADDR_W(4), .MULDIV_CYCLES(MDC)) dut (
    .clk(clk), .rst(rst), .if_instr(if_instr), .if_valid(if_valid),
    .branch_taken(branch_taken), .pc_sel(pc_sel), .if_stall(if_stall), .flush(flush),
    .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write), .ex_compare(ex_compare),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_wen(ex_mem_wen), .ex_src_b(ex_src_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal), .halted(halted)
  );

  // One in-flight instruction as the model sees it.
  typedef struct packed {
    bit v; int dest; int rw; bit ld; bit br; bit jmp; bit hlt; bit md;
    bit ua; bit ub; int s1; int s2; int alu; int cmp; int srcb;
    bit m2r; bit wen; bit ill; int fa; int fb;
  } rec_t;

  rec_t st [3];
  rec_t m_dec;
  int   mode, busy, halt_wait, ptr, checks, errors;
  bit   halted_m, prev_hold_fetch, cur_dir, cur_taken;
  bit   m_flush, m_hold, m_lu, m_accept, m_halt_acc;
  int   exp_pc;
  bit   exp_stall, exp_flush;

  logic [15:0] dir_instr [NDIR] = '{16'h012F, 16'h031F, 16'h8140, 16'h021C, 16'h6120, 16'h012F,
                                    16'h0231, 16'h0541, 16'h001F, 16'h7000, 16'hF000};
  bit          dir_taken [NDIR] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  logic [3:0]  legal_fn [10]    = '{4'hF, 4'hE, 4'hD, 4'hC, 4'h1, 4'h2, 4'hA, 4'hB, 4'h8, 4'h9};
  logic [3:0]  bad_op [8]       = '{4'h1, 4'h2, 4'h3, 4'h7, 4'h9, 4'hA, 4'hD, 4'hE};

  function automatic rec_t bubble();
    rec_t r;
    r = '0;
    r.cmp = 3;
    return r;
  endfunction

  function automatic bit writes(input rec_t r, input int s);
    return r.v && (r.rw != 0) && ((r.dest == s) || ((r.rw == 3) && (s == 0)));
  endfunction

  function automatic rec_t tbDecode(input logic [15:0] ins);
    rec_t r;
    int   opc, fn, code;
    r    = bubble();
    opc  = int'(ins[15:12]);
    fn   = int'(ins[3:0]);
    r.s1 = int'(ins[11:8]);
    r.s2 = int'(ins[7:4]);
    case (opc)
      0: begin
        case (fn)
          15: code = 0;  14: code = 1;  13: code = 2;  12: code = 3;  1: code = 4;
          2:  code = 5;  10: code = 6;  11: code = 7;  8:  code = 8;  9: code = 9;
          default: code = -1;
        endcase
        if (code < 0 || ((code == 4 || code == 5) && r.s1 == 0)) r.ill = 1;
        else begin
          r.v = 1; r.alu = code; r.ua = 1; r.ub = 1; r.dest = r.s1;
          r.md   = (code == 4 || code == 5);
          r.rw   = r.md ? 3 : 1;
          r.srcb = (code >= 6) ? 2 : 0;
        end
      end
      8:       begin r.v = 1; r.rw = 1; r.m2r = 1; r.ld = 1; r.srcb = 2; r.ub = 1; r.dest = r.s1; end
      11:      begin r.v = 1; r.wen = 1; r.srcb = 2; r.ua = 1; r.ub = 1; end
      4, 5, 6: begin r.v = 1; r.br = 1; r.cmp = opc - 4; r.ua = 1; r.ub = 1; end
      12:      begin r.v = 1; r.jmp = 1; end
      15:      r.hlt = 1;
      default: r.ill = 1;
    endcase
    return r;
  endfunction

  function automatic logic [15:0] randInstr();
    int         pick;
    logic [3:0] opc, fn, a, b;
    pick = $urandom_range(0, 15);
    if (pick <= 5 || pick == 14)  opc = 4'h0;
    else if (pick <= 7)           opc = 4'h8;
    else if (pick == 8)           opc = 4'hB;
    else if (pick == 9)           opc = 4'h4;
    else if (pick == 10)          opc = 4'h5;
    else if (pick == 11)          opc = 4'h6;
    else if (pick == 12)          opc = 4'hC;
    else if (pick == 13)          opc = bad_op[$urandom_range(0, 7)];
    else                          opc = ($urandom_range(0, 2) == 0) ? 4'hF : 4'h0;
    fn = ($urandom_range(0, 9) != 0) ? legal_fn[$urandom_range(0, 9)] : 4'($urandom_range(0, 15));
    a  = 4'($urandom_range(0, 3));
    b  = 4'($urandom_range(0, 3));
    return {opc, a, b, fn};
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic checkRegs();
    checkOutput("ex_alu_op",     {4'b0, ex_alu_op},     8'(st[0].alu));
    checkOutput("ex_reg_write",  {6'b0, ex_reg_write},  8'(st[0].rw));
    checkOutput("ex_compare",    {6'b0, ex_compare},    8'(st[0].cmp));
    checkOutput("ex_mem_to_reg", {7'b0, ex_mem_to_reg}, 8'(st[0].m2r));
    checkOutput("ex_mem_wen",    {7'b0, ex_mem_wen},    8'(st[0].wen));
    checkOutput("ex_src_b",      {6'b0, ex_src_b},      8'(st[0].srcb));
    checkOutput("fwd_a",         {6'b0, fwd_a},         8'(st[0].fa));
    checkOutput("fwd_b",         {6'b0, fwd_b},         8'(st[0].fb));
    checkOutput("illegal",       {7'b0, illegal},       8'(st[0].ill));
    checkOutput("halted",        {7'b0, halted},        8'(halted_m));
  endtask

  task automatic applyStimulus();
    if (mode == 2) halt_wait++;
    rst = 1'b0;
    if (mode == 2 && halt_wait >= 3) rst = 1'b1;
    else if (ptr >= NDIR && $urandom_range(0, 249) == 0) rst = 1'b1;
    if (!prev_hold_fetch) begin
      if (ptr < NDIR) begin
        if_instr  = dir_instr[ptr];
        if_valid  = 1'b1;
        cur_taken = dir_taken[ptr];
        cur_dir   = 1'b1;
        ptr++;
      end else begin
        if_instr = randInstr();
        if_valid = ($urandom_range(0, 9) != 0);
        cur_dir  = 1'b0;
      end
    end
    branch_taken = cur_dir ? cur_taken : 1'($urandom_range(0, 1));
  endtask

  // Expected PC-side response from the priority list, on the model's current contents.
  task automatic modelComb();
    m_dec      = tbDecode(if_instr);
    m_flush    = (mode == 0) && st[0].v && st[0].br && branch_taken;
    m_hold     = !m_flush && (busy > 0);
    m_lu       = if_valid && st[0].v && st[0].ld &&
                 ((m_dec.ua && m_dec.s1 == st[0].dest) || (m_dec.ub && m_dec.s2 == st[0].dest));
    m_halt_acc = (mode == 0) && !m_flush && !m_hold && !m_lu && if_valid && m_dec.hlt;
    m_accept   = (mode == 0) && !m_flush && !m_hold && !m_lu && if_valid && !m_dec.hlt;
    exp_pc = 1; exp_stall = 0; exp_flush = 0;
    if (rst) begin
      exp_pc = 1;
    end else if (mode != 0) begin
      exp_pc = 0; exp_stall = 1;
    end else if (m_flush) begin
      exp_pc = 3; exp_flush = 1;
    end else if (m_hold || m_lu || m_halt_acc) begin
      exp_pc = 0; exp_stall = 1;
    end else if (m_accept && m_dec.jmp) begin
      exp_pc = 2;
    end
  endtask

  task automatic modelAdvance();
    rec_t n;
    bit   empty;
    if (rst) begin
      for (int i = 0; i < 3; i++) st[i] = bubble();
      mode = 0; busy = 0; halted_m = 0; halt_wait = 0;
      return;
    end
    empty    = !st[0].v && !st[1].v && !st[2].v;
    halted_m = (mode == 2);
    if (m_hold) begin
      st[2]     = st[1];
      st[1]     = bubble();
      st[0].ill = 0;
      busy--;
    end else begin
      n = bubble();
      if (m_accept) begin
        n = m_dec;
        if (!n.ill) begin
          n.fa = !n.ua ? 0 : writes(st[0], n.s1) ? 1 : writes(st[1], n.s1) ? 2 : 0;
          n.fb = !n.ub ? 0 : writes(st[0], n.s2) ? 1 : writes(st[1], n.s2) ? 2 : 0;
        end
      end
      st[2] = st[1];
      st[1] = st[0];
      st[0] = n;
      busy  = (m_accept && n.md) ? MDC - 1 : 0;
    end
    if (m_halt_acc)                mode = 1;
    else if (mode == 1 && empty)   mode = 2;
  endtask

  initial begin
    checks = 0; errors = 0; ptr = 0; halt_wait = 0;
    cur_dir = 0; cur_taken = 0; prev_hold_fetch = 0;
    rst = 1'b1; if_valid = 1'b0; if_instr = 16'h0000; branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) st[i] = bubble();
    mode = 0; busy = 0; halted_m = 0;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      checkRegs();
      applyStimulus();
      #1;
      modelComb();
      checkOutput("pc_sel",   {6'b0, pc_sel},   8'(exp_pc));
      checkOutput("if_stall", {7'b0, if_stall}, 8'(exp_stall));
      checkOutput("flush",    {7'b0, flush},    8'(exp_flush));
      modelAdvance();
      prev_hold_fetch = exp_stall;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
